key_expansion_engine: RTL and testbench
=======================================

Name: key_expansion_engine

Overview:
Sequential AES key schedule. Latches a cipher key, expands it one 32-bit word per cycle into all round keys, then streams them out as 128-bit round keys over a valid/ready handshake. Round keys come out in forward order for the encrypt datapath or reverse order for the decrypt datapath. Key length is set by parameter (AES-128/192/256). Rcon is generated internally, with no round-number lookup.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128, 192, 256; any other value is an elaboration error
NK, KEY_BITS/32, key words (derived; not user-overridable)
NR, NK+6, number of rounds (derived)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; accepted only in IDLE
keyIn  in  KEY_BITS  cipher key; keyIn[KEY_BITS-1 -: 32] is w[0] (FIPS-197 byte order)
decrypt  in  1  sampled with start; 1 = stream rounds NR..0, 0 = stream rounds 0..NR
busy  out  1  high whenever state is not IDLE
rkValid  out  1  round key available
rkReady  in  1  consumer accepts the beat
rkData  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for round r
rkRound  out  4  round index r of the current beat
rkLast  out  1  high on the final beat (r = NR fwd, r = 0 rev)

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, rkValid, rkLast, rkData and rkRound are all 0. Rcon register = 8'h01. Word buffer contents are don't-care.
- Reset while EXPAND or STREAM aborts immediately. No partial beat survives.
- IDLE: on start=1, load w[0..NK-1] from keyIn, latch decrypt, set i=NK, kmod=0, rcon=8'h01. Go to EXPAND next cycle.
- start outside IDLE is ignored. No queueing.
- EXPAND: compute one word per cycle.
  - temp = w[i-1].
  - If kmod==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}; then rcon = xtime(rcon) (shift left, XOR 8'h1B on carry).
  - Else if NK==8 and kmod==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - Advance: i++, kmod = (kmod==NK-1) ? 0 : kmod+1. No divider.
- EXPAND ends after w[4*NR+3] is written. Cycle counts: 40 (128), 46 (192), 52 (256). STREAM starts the following cycle.
- Total start-to-first-rkValid latency = EXPAND count + 1.
- STREAM: rkValid=1. First round is 0 (fwd) or NR (rev).
  - rkData, rkRound and rkLast stay stable while rkValid && !rkReady.
  - On rkValid && rkReady, advance to the next round the following cycle. Back-to-back beats run at 1 per cycle with rkReady held high.
  - Handshake on rkLast: rkValid drops, state returns to IDLE, busy falls the same edge.
- rkReady is ignored outside STREAM.
- Buffer holds 4*(NR+1) words (max 60x32). Contents persist after completion unless the optional feature is enabled.

Optional Feature:
KEY_EXPANSION_ZEROIZE_EN
- Defined: the final handshake enters a WIPE state that clears one buffer word per cycle (4*(NR+1) cycles) and then clears the key/rcon registers. busy stays high throughout WIPE; start is ignored until IDLE.
- Undefined: no WIPE state; the final handshake returns straight to IDLE.

Decomposition:
- Package key_expansion_pkg:
  - State enum (IDLE, EXPAND, STREAM, WIPE).
  - Constant functions nk_of(KEY_BITS) and nr_of(KEY_BITS).
  - RCON_INIT = 8'h01 and xtime function.
  - S-box constant table.
- Sub-module sub_word: purely combinational, four S-box lookups, 32-bit in/out. One instance shared by both SubWord paths.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, fwd, rkReady=1:
  - rkValid after 41 cycles.
  - Beat 0 = the key.
  - Beat 1 = a0fafe1788542cb123a339392a6c7605.
  - Beat 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rkLast=1.
- Same key, decrypt=1:
  - First beat rkRound=10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Last beat rkRound=0 = the key, rkLast=1.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 13 beats.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 15 beats.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure:
  - Random rkReady toggling: rkData/rkRound stable while stalled; no beat lost or duplicated.
  - start pulsed during STREAM: ignored.
- Reset abort:
  - rst_n low mid-EXPAND: outputs 0 asynchronously.
  - New start after release produces the correct AES-128 vectors.
  - With ZEROIZE_EN: buffer reads all-zero after WIPE.

Source files
------------

// File: rtl/key_expansion_pkg.sv
// Shared types and constants for the AES key schedule: FSM states, key-size
// helpers, the Rcon step (xtime) and the AES forward S-box.
package key_expansion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2,
    WIPE   = 2'd3
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return (key_bits / 32) + 6;
  endfunction

  // Multiply by x in GF(2^8); steps Rcon without a round-number table.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_expansion_engine_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module sub_word
  import key_expansion_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_expansion_engine.sv
// Sequential AES key schedule: one expanded word per cycle, then 128-bit round
// keys streamed forward or reverse. Define KEY_EXPANSION_ZEROIZE_EN to wipe the
// word buffer after the final beat.
module key_expansion_engine
  import key_expansion_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] keyIn,
  input  logic                decrypt,
  output logic                busy,
  output logic                rkValid,
  input  logic                rkReady,
  output logic [127:0]        rkData,
  output logic [3:0]          rkRound,
  output logic                rkLast
);

  localparam int NK    = nk_of(KEY_BITS);
  localparam int NR    = nr_of(KEY_BITS);
  localparam int WORDS = 4 * (NR + 1);
  localparam int IW    = 6;

  localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);
  localparam logic [IW-1:0] NK_IDX    = IW'(NK);
  localparam logic [2:0]    KMOD_LAST = 3'(NK - 1);
  localparam logic [3:0]    NR_IDX    = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_expansion_engine: KEY_BITS must be 128, 192 or 256");
  end

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_w [WORDS];
  logic [IW-1:0]   r_i;
  logic [2:0]      r_kmod;
  logic [7:0]      r_rcon;
  logic            r_decrypt;
  logic [3:0]      r_round;

  logic [31:0]     w_prev;
  logic [31:0]     w_back;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub_out;
  logic [31:0]     w_temp;
  logic [31:0]     w_new;
  logic            w_start_ok;
  logic            w_expand_done;
  logic            w_last_beat;
  logic            w_handshake;

  assign w_prev        = r_w[r_i - 6'd1];
  assign w_back        = r_w[r_i - NK_IDX];
  assign w_start_ok    = (r_state == IDLE) && start;
  assign w_expand_done = (r_state == EXPAND) && (r_i == LAST_WORD);
  assign w_last_beat   = r_decrypt ? (r_round == 4'd0) : (r_round == NR_IDX);
  assign w_handshake   = (r_state == STREAM) && rkReady;

  // RotWord is applied only on the Rcon step, so a single S-box bank serves both paths.
  assign w_sub_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_temp = w_prev;
    if (r_kmod == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if ((NK == 8) && (r_kmod == 3'd4)) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (start) w_next_state = EXPAND;
      EXPAND: if (w_expand_done) w_next_state = STREAM;
      STREAM: begin
        if (rkReady && w_last_beat) begin
`ifdef KEY_EXPANSION_ZEROIZE_EN
          w_next_state = WIPE;
`else
          w_next_state = IDLE;
`endif
        end
      end
`ifdef KEY_EXPANSION_ZEROIZE_EN
      WIPE:   if (r_i == LAST_WORD) w_next_state = IDLE;
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != IDLE);
    rkValid = (r_state == STREAM);
    rkData  = '0;
    rkRound = '0;
    rkLast  = 1'b0;
    if (r_state == STREAM) begin
      rkData  = {r_w[{r_round, 2'b00}], r_w[{r_round, 2'b01}],
                 r_w[{r_round, 2'b10}], r_w[{r_round, 2'b11}]};
      rkRound = r_round;
      rkLast  = w_last_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i       <= '0;
      r_kmod    <= '0;
      r_rcon    <= RCON_INIT;
      r_decrypt <= 1'b0;
      r_round   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_i       <= NK_IDX;
            r_kmod    <= '0;
            r_rcon    <= RCON_INIT;
            r_decrypt <= decrypt;
            r_round   <= decrypt ? NR_IDX : 4'd0;
          end
        end
        EXPAND: begin
          r_i    <= r_i + 6'd1;
          r_kmod <= (r_kmod == KMOD_LAST) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
        end
        STREAM: begin
          if (rkReady) begin
            if (w_last_beat) r_i <= '0;
            else             r_round <= r_decrypt ? r_round - 4'd1 : r_round + 4'd1;
          end
        end
`ifdef KEY_EXPANSION_ZEROIZE_EN
        WIPE: begin
          r_i <= r_i + 6'd1;
          if (r_i == LAST_WORD) begin
            r_rcon    <= '0;
            r_kmod    <= '0;
            r_decrypt <= 1'b0;
            r_round   <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: the word buffer is plain storage with no reset; its contents are
  // don't-care until the key is loaded, which keeps it mappable to RAM/regfile.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      for (int j = 0; j < NK; j++) begin
        r_w[j] <= keyIn[KEY_BITS-1-32*j -: 32];
      end
    end else if (r_state == EXPAND) begin
      r_w[r_i] <= w_new;
    end
`ifdef KEY_EXPANSION_ZEROIZE_EN
    else if (r_state == WIPE) begin
      r_w[r_i] <= '0;
    end
`endif
  end

  logic w_unused;
  assign w_unused = w_handshake;

endmodule

// File: tb/tb_key_expansion_engine.sv
// Self-checking bench for key_expansion_engine at all three key sizes, against
// a key-schedule model built from GF(2^8) arithmetic.
module tb_key_expansion_engine;

  logic         clk;
  logic         rst_n;
  logic         start    [3];
  logic         decrypt  [3];
  logic         rk_ready [3];
  logic [255:0] key_in   [3];
  logic         busy     [3];
  logic         rk_valid [3];
  logic         rk_last  [3];
  logic [127:0] rk_data  [3];
  logic [3:0]   rk_round [3];

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb  [256];
  logic [31:0]  mw  [60];
  logic [127:0] cap [15];

  localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_expansion_engine #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .keyIn(key_in[0][127:0]),
    .decrypt(decrypt[0]), .busy(busy[0]), .rkValid(rk_valid[0]), .rkReady(rk_ready[0]),
    .rkData(rk_data[0]), .rkRound(rk_round[0]), .rkLast(rk_last[0]));

  key_expansion_engine #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .keyIn(key_in[1][191:0]),
    .decrypt(decrypt[1]), .busy(busy[1]), .rkValid(rk_valid[1]), .rkReady(rk_ready[1]),
    .rkData(rk_data[1]), .rkRound(rk_round[1]), .rkLast(rk_last[1]));

  key_expansion_engine #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .keyIn(key_in[2]),
    .decrypt(decrypt[2]), .busy(busy[2]), .rkValid(rk_valid[2]), .rkReady(rk_ready[2]),
    .rkData(rk_data[2]), .rkRound(rk_round[2]), .rkLast(rk_last[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic build_model(input int nkw, input logic [255:0] key);
    int nr;
    logic [31:0] t;
    nr = nkw + 6;
    for (int i = 0; i < nkw; i++) mw[i] = key[32*(nkw-1-i) +: 32];
    for (int i = nkw; i < 4*(nr+1); i++) begin
      t = mw[i-1];
      if (i % nkw == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nkw), 24'h0};
      else if (nkw > 6 && i % nkw == 4)
        t = subw(t);
      mw[i] = mw[i-nkw] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic run_session(input int k, input logic [255:0] key, input logic dec,
                             input bit stall, input bit poke);
    int nkw, nr, cycles, b, r, guard;
    logic rdy;
    nkw = 4 + 2*k;
    nr  = nkw + 6;
    build_model(nkw, key);
    for (int i = 0; i < 15; i++) cap[i] = '0;
    cycles = 0;
    while (busy[k] && cycles < 200) begin @(negedge clk); cycles++; end
    check("idle_before_start", busy[k], 1'b0);
    key_in[k]  = key;
    decrypt[k] = dec;
    start[k]   = 1'b1;
    @(negedge clk);
    start[k]  = 1'b0;
    key_in[k] = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
    cycles = 1;
    check("busy_after_start", busy[k], 1'b1);
    while (!rk_valid[k] && cycles < 300) begin @(negedge clk); cycles++; end
    check("latency", 128'(cycles), 128'(4*nr + 4 - nkw + 1));
    b = 0;
    guard = 0;
    while (b <= nr && guard < 1000) begin
      r   = dec ? nr - b : b;
      rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      rk_ready[k] = rdy;
      start[k] = poke && ($urandom_range(0, 3) == 0);
      if (start[k]) begin
        decrypt[k] = ~dec;
        key_in[k]  = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
      end
      check("rk_valid", rk_valid[k], 1'b1);
      check("rk_data", rk_data[k], exp_rk(r));
      check("rk_round", rk_round[k], 128'(r));
      check("rk_last", rk_last[k], (b == nr));
      if (rdy) begin
        cap[r] = rk_data[k];
        b++;
      end
      guard++;
      @(negedge clk);
    end
    start[k]    = 1'b0;
    rk_ready[k] = 1'b0;
    check("beat_count", 128'(b), 128'(nr + 1));
    check("valid_after_last", rk_valid[k], 1'b0);
`ifdef KEY_EXPANSION_ZEROIZE_EN
    check("busy_in_wipe", busy[k], 1'b1);
    cycles = 0;
    while (busy[k] && cycles < 200) begin @(negedge clk); cycles++; end
    check("wipe_length", 128'(cycles), 128'(4*(nr+1)));
`else
    check("busy_after_last", busy[k], 1'b0);
`endif
  endtask

  task automatic check_quiet(input int k, input string tag);
    check({tag, "_busy"},  busy[k],     1'b0);
    check({tag, "_valid"}, rk_valid[k], 1'b0);
    check({tag, "_data"},  rk_data[k],  '0);
    check({tag, "_round"}, rk_round[k], '0);
    check({tag, "_last"},  rk_last[k],  1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; decrypt[k] = 1'b0; rk_ready[k] = 1'b0; key_in[k] = '0;
    end
    build_sbox();
    #3;
    for (int k = 0; k < 3; k++) check_quiet(k, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_session(0, KEY128, 1'b0, 1'b0, 1'b0);
    check("aes128_fwd_r0", cap[0], KEY128[127:0]);
    check("aes128_fwd_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_fwd_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_session(0, KEY128, 1'b1, 1'b0, 1'b0);
    check("aes128_rev_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes128_rev_r0", cap[0], KEY128[127:0]);

    run_session(1, KEY192, 1'b0, 1'b0, 1'b0);
    check("aes192_r12", cap[12], 128'he98ba06f448c773c8ecc720401002202);

    run_session(2, KEY256, 1'b1, 1'b0, 1'b0);
    check("aes256_r14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

    for (int n = 0; n < 6; n++) begin
      run_session(n % 3, {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()},
                  ($urandom_range(0, 1) == 1), 1'b1, (n % 2) == 1);
    end

    // Abort a fresh expansion partway through, then rerun from a clean start.
    @(negedge clk);
    key_in[0] = KEY128;
    decrypt[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_busy_before", busy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1 check_quiet(0, "abort");
    @(negedge clk);
    rst_n = 1'b1;

    run_session(0, KEY128, 1'b0, 1'b1, 1'b0);
    check("post_abort_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("post_abort_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
